// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: bus widths, memory command
// codes, requester ownership and drain-state enums.
package global_defs;

   localparam int ADDR_W   = 32;
   localparam int BLOCK_W  = 64;
   localparam int TAG_W    = 4;
   localparam int NUM_TAGS = 16;

   localparam logic [1:0] CMD_NONE  = 2'd0;
   localparam logic [1:0] CMD_LOAD  = 2'd1;
   localparam logic [1:0] CMD_STORE = 2'd2;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_Q    = 2'd1,
      OWNER_R    = 2'd2
   } arb_owner_e;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } drain_state_e;

endpackage

// File: rtl/mem_port_arbiter_tag.sv
// mem_tag_table: per-tag owner/valid table for loads in flight, plus a count
// of live entries. A return and an allocation may land in the same cycle.
module mem_tag_table
   import global_defs::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alloc,
   input  logic [TAG_W-1:0] alloc_tag,
   input  logic [1:0]       alloc_owner,
   input  logic [TAG_W-1:0] lookup_tag,
   output logic             lookup_hit,
   output logic [1:0]       lookup_owner,
   output logic [TAG_W-1:0] count,
   output logic [TAG_W-1:0] count_next
);

   logic [NUM_TAGS-1:0] valid;
   arb_owner_e          owner [NUM_TAGS];

   assign lookup_hit   = (lookup_tag != '0) && valid[lookup_tag];
   assign lookup_owner = owner[lookup_tag];
   assign count_next   = count - TAG_W'(lookup_hit) + TAG_W'(alloc);

   // The allocate write comes after the free so a tag returned and reissued
   // in the same cycle ends up valid with its new owner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         count <= '0;
         for (int i = 0; i < NUM_TAGS; i++) owner[i] <= OWNER_NONE;
      end else begin
         if (lookup_hit) valid[lookup_tag] <= 1'b0;
         if (alloc) begin
            valid[alloc_tag] <= 1'b1;
            owner[alloc_tag] <= arb_owner_e'(alloc_owner);
         end
         count <= count_next;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between query loads, reference loads
// and KNN writebacks. Define MEM_ARB_RR_EN for round-robin between q and r.
module mem_port_arbiter
   import global_defs::*;
#(
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               q_req,
   input  logic [ADDR_W-1:0]  q_addr,
   input  logic               r_req,
   input  logic [ADDR_W-1:0]  r_addr,
   input  logic               w_req,
   input  logic [ADDR_W-1:0]  w_addr,
   input  logic [BLOCK_W-1:0] w_data,
   output logic               q_gnt,
   output logic               r_gnt,
   output logic               w_gnt,
   output logic               q_rsp_valid,
   output logic               r_rsp_valid,
   output logic [BLOCK_W-1:0] rsp_data,
   input  logic               flush,
   output logic               drained,
   output logic               stray_tag,
   output logic [1:0]         proc2mem_command,
   output logic [ADDR_W-1:0]  proc2mem_addr,
   output logic [BLOCK_W-1:0] proc2mem_data,
   input  logic [TAG_W-1:0]   mem2proc_transaction_tag,
   input  logic [BLOCK_W-1:0] mem2proc_data,
   input  logic [TAG_W-1:0]   mem2proc_data_tag
);

   localparam logic [TAG_W-1:0] MAX_LOADS = TAG_W'(MAX_OUTSTANDING);

   drain_state_e     state, state_next;
   arb_owner_e       load_sel;
   logic             accept, loads_open, alloc, lookup_hit, store_pending, drain_ok;
   logic [1:0]       alloc_owner, lookup_owner;
   logic [TAG_W-1:0] count, count_next;

   assign accept     = rst_n && (mem2proc_transaction_tag != '0);
   assign loads_open = (state == RUN) && !flush && (count < MAX_LOADS);

`ifdef MEM_ARB_RR_EN
   logic last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     last_q <= 1'b0;
      else if (q_gnt) last_q <= 1'b1;
      else if (r_gnt) last_q <= 1'b0;
   end

   // When both loads compete, whoever was granted last yields.
   always_comb begin
      load_sel = OWNER_NONE;
      if (loads_open) begin
         if (q_req && r_req) load_sel = last_q ? OWNER_R : OWNER_Q;
         else if (q_req)     load_sel = OWNER_Q;
         else if (r_req)     load_sel = OWNER_R;
      end
   end
`else
   always_comb begin
      load_sel = OWNER_NONE;
      if (loads_open) begin
         if (q_req)      load_sel = OWNER_Q;
         else if (r_req) load_sel = OWNER_R;
      end
   end
`endif

   // Stores always win the port; a driven request is granted only if memory
   // hands back a non-zero transaction tag in the same cycle.
   always_comb begin
      proc2mem_command = CMD_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      q_gnt            = 1'b0;
      r_gnt            = 1'b0;
      w_gnt            = 1'b0;
      alloc            = 1'b0;
      alloc_owner      = OWNER_NONE;
      if (rst_n) begin
         if (w_req) begin
            proc2mem_command = CMD_STORE;
            proc2mem_addr    = w_addr;
            proc2mem_data    = w_data;
            w_gnt            = accept;
         end else if (load_sel != OWNER_NONE) begin
            proc2mem_command = CMD_LOAD;
            proc2mem_addr    = (load_sel == OWNER_Q) ? q_addr : r_addr;
            q_gnt            = accept && (load_sel == OWNER_Q);
            r_gnt            = accept && (load_sel == OWNER_R);
            alloc            = accept;
            alloc_owner      = load_sel;
         end
      end
   end

   mem_tag_table u_tag_table (
      .clk          (clk),
      .rst_n        (rst_n),
      .alloc        (alloc),
      .alloc_tag    (mem2proc_transaction_tag),
      .alloc_owner  (alloc_owner),
      .lookup_tag   (mem2proc_data_tag),
      .lookup_hit   (lookup_hit),
      .lookup_owner (lookup_owner),
      .count        (count),
      .count_next   (count_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_rsp_valid <= 1'b0;
         r_rsp_valid <= 1'b0;
         rsp_data    <= '0;
         stray_tag   <= 1'b0;
      end else begin
         q_rsp_valid <= lookup_hit && (lookup_owner == OWNER_Q);
         r_rsp_valid <= lookup_hit && (lookup_owner == OWNER_R);
         if (lookup_hit) rsp_data <= mem2proc_data;
         if ((mem2proc_data_tag != '0) && !lookup_hit) stray_tag <= 1'b1;
      end
   end

   // Drain completes once the table will be empty after this edge and no
   // store is still waiting for the port.
   assign store_pending = w_req && !w_gnt;
   assign drain_ok      = (count_next == '0) && !store_pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (flush) state_next = drain_ok ? DONE : DRAIN;
         DRAIN:   if (drain_ok) state_next = DONE;
         DONE:    if (!flush) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   assign drained = (state == DONE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then random traffic against a table-based reference model.
module tb_mem_port_arbiter;
   import global_defs::*;

   localparam int MAXO = 2;

   logic        clk = 1'b0;
   logic        rst_n, q_req, r_req, w_req, flush;
   logic [31:0] q_addr, r_addr, w_addr;
   logic [63:0] w_data, mem2proc_data, rsp_data, proc2mem_data;
   logic        q_gnt, r_gnt, w_gnt, q_rsp_valid, r_rsp_valid, drained, stray_tag;
   logic [1:0]  proc2mem_command;
   logic [31:0] proc2mem_addr;
   logic [3:0]  mem2proc_transaction_tag, mem2proc_data_tag;

   int checks = 0;
   int failures = 0;

   mem_port_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rst_n(rst_n),
      .q_req(q_req), .q_addr(q_addr), .r_req(r_req), .r_addr(r_addr),
      .w_req(w_req), .w_addr(w_addr), .w_data(w_data),
      .q_gnt(q_gnt), .r_gnt(r_gnt), .w_gnt(w_gnt),
      .q_rsp_valid(q_rsp_valid), .r_rsp_valid(r_rsp_valid), .rsp_data(rsp_data),
      .flush(flush), .drained(drained), .stray_tag(stray_tag),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data),
      .mem2proc_transaction_tag(mem2proc_transaction_tag),
      .mem2proc_data(mem2proc_data), .mem2proc_data_tag(mem2proc_data_tag)
   );

   always #5 clk = ~clk;

   // Reference model: which tags are live and who owns them (1=q, 2=r)
   bit          mv [16];
   int          mo [16];
   int          mcnt, mmode;
   bit          mstray, eqv, erv;
   logic [63:0] edata;
`ifdef MEM_ARB_RR_EN
   bit          mlastq;
`endif
   logic [1:0]  ecmd;
   logic [31:0] eaddr;
   logic [63:0] ewdata;
   bit          eqg, erg, ewg;
   int          eload;
   int          inflight [$];

   task automatic modelReset();
      for (int i = 0; i < 16; i++) begin mv[i] = 0; mo[i] = 0; end
      mcnt = 0; mmode = 0; mstray = 0; eqv = 0; erv = 0; edata = '0;
`ifdef MEM_ARB_RR_EN
      mlastq = 0;
`endif
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelIssue();
      bit acc, pickq;
      ecmd = 2'd0; eaddr = '0; ewdata = '0; eqg = 0; erg = 0; ewg = 0; eload = 0;
      if (rst_n) begin
         acc = (mem2proc_transaction_tag != 0);
         if (w_req) begin
            ecmd = 2'd2; eaddr = w_addr; ewdata = w_data; ewg = acc;
         end else if (mmode == 0 && !flush && mcnt < MAXO && (q_req || r_req)) begin
`ifdef MEM_ARB_RR_EN
            pickq = q_req && (!r_req || !mlastq);
`else
            pickq = q_req;
`endif
            ecmd  = 2'd1;
            eaddr = pickq ? q_addr : r_addr;
            eqg   = acc && pickq;
            erg   = acc && !pickq;
            eload = pickq ? 1 : 2;
         end
      end
   endtask

   task automatic compareModel();
      modelIssue();
      checkOutput("command", proc2mem_command, ecmd);
      checkOutput("addr", proc2mem_addr, eaddr);
      checkOutput("data", proc2mem_data, ewdata);
      checkOutput("q_gnt", q_gnt, eqg);
      checkOutput("r_gnt", r_gnt, erg);
      checkOutput("w_gnt", w_gnt, ewg);
      if (!rst_n) begin
         checkOutput("rst_q_rsp", q_rsp_valid, 0);
         checkOutput("rst_r_rsp", r_rsp_valid, 0);
         checkOutput("rst_rsp_data", rsp_data, 0);
         checkOutput("rst_drained", drained, 0);
         checkOutput("rst_stray", stray_tag, 0);
      end else begin
         checkOutput("q_rsp_valid", q_rsp_valid, eqv);
         checkOutput("r_rsp_valid", r_rsp_valid, erv);
         if (eqv || erv) checkOutput("rsp_data", rsp_data, edata);
         checkOutput("drained", drained, mmode == 2);
         checkOutput("stray_tag", stray_tag, mstray);
      end
   endtask

   task automatic modelAdvance();
      int  dt, tt;
      bit  hit, store_pend;
      if (!rst_n) begin
         modelReset();
         return;
      end
      dt  = mem2proc_data_tag;
      tt  = mem2proc_transaction_tag;
      hit = (dt != 0) && mv[dt];
      eqv = hit && mo[dt] == 1;
      erv = hit && mo[dt] == 2;
      if (hit) begin edata = mem2proc_data; mv[dt] = 0; mcnt--; end
      if (dt != 0 && !hit) mstray = 1;
      if (eload != 0 && tt != 0) begin
         mv[tt] = 1; mo[tt] = eload; mcnt++;
`ifdef MEM_ARB_RR_EN
         mlastq = (eload == 1);
`endif
      end
      store_pend = w_req && !ewg;
      case (mmode)
         0: if (flush) mmode = (mcnt == 0 && !store_pend) ? 2 : 1;
         1: if (mcnt == 0 && !store_pend) mmode = 2;
         default: if (!flush) mmode = 0;
      endcase
   endtask

   task automatic applyStimulus(input logic qr, input logic [31:0] qa, input logic rr,
                                input logic [31:0] ra, input logic wr, input logic [31:0] wa,
                                input logic [63:0] wd, input int tt, input int dt,
                                input logic [63:0] dd);
      q_req = qr; q_addr = qa; r_req = rr; r_addr = ra;
      w_req = wr; w_addr = wa; w_data = wd;
      mem2proc_transaction_tag = 4'(tt);
      mem2proc_data_tag = 4'(dt);
      mem2proc_data = dd;
      #3;
   endtask

   task automatic endCycle();
      compareModel();
      modelAdvance();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int dt, input logic [63:0] dd);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, dt, dd);
   endtask

   function automatic bit inInflight(input int t);
      foreach (inflight[i]) if (inflight[i] == t) return 1;
      return 0;
   endfunction

   function automatic int freeTag();
      int t;
      for (int n = 0; n < 32; n++) begin
         t = $urandom_range(15, 1);
         if (!inInflight(t)) return t;
      end
      return 0;
   endfunction

   initial begin
      bit          expq [4];
      bit          pq, pr, pw;
      logic [31:0] pqa, pra, pwa;
      logic [63:0] pwd, dd;
      int          dt, tt, k;

      rst_n = 0; flush = 0;
      modelReset();
      idle(0, 0);
      @(posedge clk); #1;

      // Reset state
      idle(0, 0);
      checkOutput("reset_drained", drained, 0);
      checkOutput("reset_stray", stray_tag, 0);
      checkOutput("reset_cmd", proc2mem_command, 0);
      endCycle();
      idle(0, 0);
      endCycle();
      rst_n = 1;

      // Single query load with tag 3, returned one cycle later
      applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 3, 0, 0);
      checkOutput("q_load_gnt", q_gnt, 1);
      checkOutput("q_load_cmd", proc2mem_command, 1);
      checkOutput("q_load_addr", proc2mem_addr, 32'h100);
      endCycle();
      idle(3, 64'hDEAD_BEEF_0000_0003);
      checkOutput("rsp_not_yet", q_rsp_valid, 0);
      endCycle();
      idle(0, 0);
      checkOutput("rsp_valid", q_rsp_valid, 1);
      checkOutput("rsp_payload", rsp_data, 64'hDEAD_BEEF_0000_0003);
      endCycle();

      // Store beats a concurrent query
      applyStimulus(1, 32'h140, 0, 0, 1, 32'h200, 64'hCAFE, 5, 0, 0);
      checkOutput("store_cmd", proc2mem_command, 2);
      checkOutput("store_addr", proc2mem_addr, 32'h200);
      checkOutput("store_data", proc2mem_data, 64'hCAFE);
      checkOutput("store_wgnt", w_gnt, 1);
      checkOutput("store_qblocked", q_gnt, 0);
      endCycle();
      applyStimulus(1, 32'h140, 0, 0, 0, 0, 0, 6, 0, 0);
      checkOutput("q_after_store", q_gnt, 1);
      checkOutput("q_after_store_addr", proc2mem_addr, 32'h140);
      endCycle();

      // Outstanding limit of two
      applyStimulus(0, 0, 1, 32'h180, 0, 0, 0, 7, 0, 0);
      checkOutput("r_second_load", r_gnt, 1);
      endCycle();
      applyStimulus(1, 32'h1C0, 0, 0, 0, 0, 0, 8, 0, 0);
      checkOutput("cap_cmd_none", proc2mem_command, 0);
      checkOutput("cap_q_blocked", q_gnt, 0);
      endCycle();
      applyStimulus(1, 32'h1C0, 0, 0, 1, 32'h240, 64'hBEEF, 8, 0, 0);
      checkOutput("cap_store_cmd", proc2mem_command, 2);
      checkOutput("cap_store_gnt", w_gnt, 1);
      endCycle();
      applyStimulus(1, 32'h1C0, 0, 0, 0, 0, 0, 9, 6, 64'h6666);
      checkOutput("cap_still_full", q_gnt, 0);
      endCycle();
      applyStimulus(1, 32'h1C0, 0, 0, 0, 0, 0, 9, 0, 0);
      checkOutput("cap_freed_gnt", q_gnt, 1);
      checkOutput("cap_rsp6", rsp_data, 64'h6666);
      endCycle();

      // Flush with two loads outstanding (tags 7 and 9)
      flush = 1;
      applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 10, 0, 0);
      checkOutput("flush_q_blocked", q_gnt, 0);
      endCycle();
      applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 10, 7, 64'h7777);
      checkOutput("flush_drained_early", drained, 0);
      endCycle();
      applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 10, 9, 64'h9999);
      checkOutput("flush_drained_last_ret", drained, 0);
      checkOutput("flush_r_rsp", r_rsp_valid, 1);
      endCycle();
      applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 10, 0, 0);
      checkOutput("flush_drained", drained, 1);
      checkOutput("flush_done_q_blocked", q_gnt, 0);
      endCycle();
      flush = 0;
      applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 10, 0, 0);
      checkOutput("unflush_drained_hold", drained, 1);
      endCycle();
      applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 10, 0, 0);
      checkOutput("unflush_run", drained, 0);
      checkOutput("unflush_q_gnt", q_gnt, 1);
      endCycle();
      idle(10, 64'hAAAA);
      endCycle();

      // Flush when nothing is outstanding
      flush = 1;
      idle(0, 0);
      endCycle();
      flush = 0;
      idle(0, 0);
      checkOutput("quick_drained", drained, 1);
      endCycle();

      // Return of a never-allocated tag
      idle(9, 64'h1234);
      endCycle();
      idle(0, 0);
      checkOutput("stray_set", stray_tag, 1);
      checkOutput("stray_no_qrsp", q_rsp_valid, 0);
      checkOutput("stray_no_rrsp", r_rsp_valid, 0);
      endCycle();
      rst_n = 0;
      idle(0, 0);
      checkOutput("stray_cleared", stray_tag, 0);
      endCycle();
      rst_n = 1;

      // q and r both requesting continuously
`ifdef MEM_ARB_RR_EN
      expq[0] = 1; expq[1] = 0; expq[2] = 1; expq[3] = 0;
`else
      expq[0] = 1; expq[1] = 1; expq[2] = 1; expq[3] = 1;
`endif
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 32'h400 + 32'(4 * i), 1, 32'h500, 0, 0, 0, i + 1, i, 64'h10 + 64'(i));
         checkOutput("both_q_gnt", q_gnt, expq[i]);
         checkOutput("both_r_gnt", r_gnt, !expq[i]);
         endCycle();
      end
      idle(4, 64'h14);
      endCycle();

      // Random traffic, with one reset in the middle to orphan in-flight tags
      inflight.delete();
      pq = 0; pr = 0; pw = 0; pqa = 0; pra = 0; pwa = 0; pwd = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         rst_n = !(cyc >= 700 && cyc < 702);
         if (!pq && $urandom_range(3) == 0) begin pq = 1; pqa = $urandom; end
         if (!pr && $urandom_range(3) == 0) begin pr = 1; pra = $urandom; end
         if (!pw && $urandom_range(7) == 0) begin pw = 1; pwa = $urandom; pwd = {$urandom, $urandom}; end
         if ($urandom_range(39) == 0) flush = !flush;
         dt = 0;
         if (inflight.size() > 0 && $urandom_range(2) == 0) begin
            k = $urandom_range(inflight.size() - 1);
            dt = inflight[k];
            inflight.delete(k);
         end else if ($urandom_range(59) == 0) begin
            dt = freeTag();
         end
         tt = ($urandom_range(3) == 0) ? 0 : freeTag();
         dd = {$urandom, $urandom};
         applyStimulus(pq, pqa, pr, pra, pw, pwa, pwd, tt, dt, dd);
         endCycle();
         if (eload != 0 && tt != 0) inflight.push_back(tt);
         if (eqg) pq = 0;
         if (erg) pr = 0;
         if (ewg) pw = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 8, SHALL set the maximum number of loads in flight (1..15).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-004 q_req, r_req, w_req  in  1 each  SHALL carry the query-load, reference-load and KNN-writeback requests.
REQ-005 q_addr, r_addr, w_addr  in  ADDR each  SHALL be the request addresses; w_data  in  MEM_BLOCK  SHALL be the store data.
REQ-006 q_gnt, r_gnt, w_gnt  out  1 each  SHALL pulse for one cycle when that request is accepted.
REQ-007 q_rsp_valid, r_rsp_valid  out  1 each, with rsp_data  out  MEM_BLOCK, SHALL carry returned load data.
REQ-008 flush  in  1  SHALL request a drain; drained  out  1  SHALL indicate drain complete.
REQ-009 stray_tag  out  1  SHALL be a sticky error flag.
REQ-010 proc2mem_command, proc2mem_addr, proc2mem_data  out; mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag  in  SHALL form the memory port (MEM_COMMAND/ADDR/MEM_BLOCK/MEM_TAG).

Function
REQ-011 Issue SHALL be combinational: the selected request drives command/addr/data in the same cycle; all other cycles SHALL drive NONE, 0, 0.
REQ-012 A request SHALL be accepted when mem2proc_transaction_tag != 0 in the cycle it is driven; the gnt pulse SHALL occur in that cycle; a requester SHALL hold req/addr/data until its gnt.
REQ-013 Priority SHALL be w > q > r; a store SHALL issue as STORE, a load as LOAD.
REQ-014 A load SHALL NOT issue while outstanding == MAX_OUTSTANDING; a store SHALL still issue.
REQ-015 On load acceptance, the tag table entry [tag] SHALL record the owner (q/r) with its valid bit set, and outstanding SHALL increment.
REQ-016 When mem2proc_data_tag != 0 matches a valid entry, that entry SHALL clear, outstanding SHALL decrement, and the owner's rsp_valid SHALL assert with rsp_data registered on the next cycle (1-cycle latency).
REQ-017 A non-zero data tag with no valid entry SHALL be dropped and SHALL set stray_tag, which stays set until reset.
REQ-018 On a same-cycle accept and return, the free SHALL be applied before the allocate; the net change of outstanding SHALL be 0, and reuse of the same tag SHALL be legal.
REQ-019 Drain FSM states: RUN, DRAIN, DONE. RUN->DRAIN on flush; in DRAIN, loads SHALL be blocked; DRAIN->DONE when outstanding == 0 and no store is pending; drained = (state == DONE); DONE->RUN when flush deasserts.
REQ-020 A flush asserted with outstanding == 0 SHALL reach DONE in one cycle.

Reset
REQ-021 Reset asserted SHALL: clear the tag table, outstanding and stray_tag; set state to RUN; drive all gnt/rsp_valid/drained to 0 and rsp_data to 0.
REQ-022 A reset applied mid-transaction SHALL orphan returns for pre-reset tags, which then set stray_tag (per REQ-017).

Configuration
REQ-023 With MEM_ARB_RR_EN defined, q and r SHALL alternate by round-robin (last-granted loses ties), with w still highest priority; without it, fixed priority (REQ-013) SHALL apply.

Structure
REQ-024 The arb_owner_e enum (NONE/Q/R) and the drain-state enum SHALL live in the shared global_defs package.
REQ-025 The tag table SHALL be a sub-module mem_tag_table (alloc, free, lookup, count).

Verification
REQ-026 q_req with addr 0x100 and tag 3 -> q_gnt in the same cycle; a data return with tag 3 -> q_rsp_valid one cycle later carrying the data.
REQ-027 w_req and q_req together -> STORE to w_addr first; q is granted on the next accepting cycle.
REQ-028 MAX_OUTSTANDING=2 with two loads unreturned -> a third load SHALL NOT issue; a store still issues; one return -> the load issues.
REQ-029 flush with 2 loads outstanding -> drained rises the cycle after the last return, and no loads issue meanwhile.
REQ-030 Data tag 9 with no allocation -> stray_tag=1 and no rsp_valid; a reset with rst_n low clears it.
REQ-031 MEM_ARB_RR_EN defined with q and r requesting continuously -> grants alternate q, r, q, r.
